vid_mem_arbiter: RTL and testbench

//  Shares the single SDRAM/SRAM word port between the 1024x768/640x480 video fetcher (VID) and the CPU.

---
 rtl/vid_mem_arbiter.sv | 108 ++++++++++
 tb/tb_vid_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_mem_arbiter.sv
// Shares one memory word port between video fetches (strict priority) and the CPU; one transaction in flight.
// Registered outputs: a request reaches mem_req one edge after it is seen in IDLE; requesters hold until acked.
module vid_mem_arbiter #(
  parameter int unsigned        ADR_W     = 22,
  parameter logic [ADR_W-1:0]   VID_BASE  = 22'h3A000,
  parameter int unsigned        VID_WORDS = 9600
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vid_req,
  input  logic             vid_frame,
  output logic [31:0]      viddata,
  output logic             vid_ovr,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  input  logic [ADR_W-1:0] cpu_adr,
  input  logic [31:0]      cpu_wdata,
  input  logic [3:0]       cpu_be,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic [ADR_W-1:0] mem_adr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack
);

  localparam int unsigned      CNT_W    = $clog2(VID_WORDS);
  localparam logic [CNT_W-1:0] VCNT_MAX = CNT_W'(VID_WORDS - 1);

  typedef enum logic [1:0] {IDLE, VID, CPU} state_t;

  state_t           state;
  logic             vid_pend;
  logic [CNT_W-1:0] vcnt;
  logic             vid_ack;

  assign vid_ack = (state == VID) && mem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      vid_pend  <= 1'b0;
      vcnt      <= '0;
      viddata   <= '0;
      vid_ovr   <= 1'b0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      cpu_ack  <= 1'b0;
      vid_pend <= vid_req | (vid_pend & ~vid_ack);
      if (vid_req && vid_pend && !vid_ack)
        vid_ovr <= 1'b1;

      // A frame rewind overrides the increment of a coincident video ack.
      if (vid_frame)
        vcnt <= '0;
      else if (vid_ack && vcnt != VCNT_MAX)
        vcnt <= vcnt + 1'b1;

      case (state)
        IDLE: begin
          if (vid_pend) begin
            state     <= VID;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_adr   <= VID_BASE + ADR_W'(vcnt);
            mem_wdata <= '0;
            mem_be    <= 4'hF;
          end else if ((cpu_rd || cpu_wr) && !vid_req) begin
            // A video strobe arriving together with a CPU request is let through first.
            state     <= CPU;
            mem_req   <= 1'b1;
            mem_we    <= cpu_wr;
            mem_adr   <= cpu_adr;
            mem_wdata <= cpu_wdata;
            mem_be    <= cpu_be;
          end
        end
        VID: begin
          if (mem_ack) begin
            viddata <= mem_rdata;
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        CPU: begin
          if (mem_ack) begin
            cpu_ack <= 1'b1;
            if (!mem_we)
              cpu_rdata <= mem_rdata;
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vid_mem_arbiter.sv
// Bench for vid_mem_arbiter: directed scenarios plus a random phase, all checked against a per-edge reference model.
module tb_vid_mem_arbiter;
  localparam int          VID_WORDS = 9600;
  localparam logic [21:0] VID_BASE  = 22'h3A000;

  logic        clk = 1'b0;
  logic        rst;
  logic        vid_req, vid_frame, vid_ovr;
  logic [31:0] viddata;
  logic        cpu_rd, cpu_wr, cpu_ack;
  logic [21:0] cpu_adr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_be;
  logic        mem_req, mem_we, mem_ack;
  logic [21:0] mem_adr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  vid_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .vid_req(vid_req), .vid_frame(vid_frame), .viddata(viddata), .vid_ovr(vid_ovr),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: what the port should look like after each edge.
  logic        m_busy, m_vid, m_we, m_pend, m_ovr;
  logic [21:0] m_adr;
  logic [31:0] m_wdata, m_viddata, m_rdata;
  logic [3:0]  m_be;
  int          m_cnt;
  logic        vstart;
  logic        auto_mem, auto_cpu, auto_vid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic        vr, vf, crd, cwr, mack, ack, vack, cack, sv, sc;
    logic [21:0] ca;
    logic [31:0] cw, rd;
    logic [3:0]  cb;
    if (auto_mem) begin
      mem_ack   = mem_req && ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
    end
    vr = vid_req; vf = vid_frame; crd = cpu_rd; cwr = cpu_wr; mack = mem_ack;
    ca = cpu_adr; cw = cpu_wdata; cb = cpu_be; rd = mem_rdata;
    @(posedge clk);
    #1;
    ack  = m_busy && mack;
    vack = ack && m_vid;
    cack = ack && !m_vid;
    sv   = !m_busy && m_pend;
    sc   = !m_busy && !m_pend && !vr && (crd || cwr);
    vstart = sv;
    if (vack) m_viddata = rd;
    if (cack && !m_we) m_rdata = rd;
    if (vr && m_pend && !vack) m_ovr = 1'b1;
    if (sv) begin m_vid = 1'b1; m_we = 1'b0; m_adr = VID_BASE + 22'(m_cnt); m_be = 4'hF; end
    if (sc) begin m_vid = 1'b0; m_we = cwr; m_adr = ca; m_wdata = cw; m_be = cb; end
    m_busy = (m_busy && !ack) || sv || sc;
    m_pend = vr || (m_pend && !vack);
    if (vf) m_cnt = 0;
    else if (vack) m_cnt = (m_cnt + 1 > VID_WORDS - 1) ? VID_WORDS - 1 : m_cnt + 1;

    chk("mem_req", mem_req, m_busy);
    if (m_busy) begin
      chk("mem_we", mem_we, m_we);
      chk("mem_adr", mem_adr, m_adr);
      chk("mem_be", mem_be, m_be);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("cpu_ack", cpu_ack, cack);
    chk("viddata", viddata, m_viddata);
    chk("cpu_rdata", cpu_rdata, m_rdata);
    chk("vid_ovr", vid_ovr, m_ovr);

    if (auto_cpu) begin
      if (cpu_ack) begin
        cpu_rd = 1'b0; cpu_wr = 1'b0;
      end else if (!(cpu_rd || cpu_wr) && $urandom_range(0, 3) == 0) begin
        cpu_rd    = 1'($urandom_range(0, 1));
        cpu_wr    = !cpu_rd || ($urandom_range(0, 3) == 0);
        cpu_adr   = 22'($urandom);
        cpu_wdata = $urandom;
        cpu_be    = 4'($urandom);
      end
    end
    if (auto_vid) begin
      vid_req   = ($urandom_range(0, 9) == 0);
      vid_frame = ($urandom_range(0, 99) == 0);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic ack_now(input logic [31:0] d);
    mem_ack = 1'b1; mem_rdata = d;
    step();
    mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    vid_req = 0; vid_frame = 0; cpu_rd = 0; cpu_wr = 0; mem_ack = 0;
    cpu_adr = 0; cpu_wdata = 0; cpu_be = 0; mem_rdata = 0;
    rst = 1'b1;
    #1;
    chk("rst_mem", {mem_req, mem_we, mem_adr, mem_wdata, mem_be}, 64'd0);
    chk("rst_viddata", viddata, 32'd0);
    chk("rst_cpu", {cpu_ack, cpu_rdata, vid_ovr}, 64'd0);
    m_busy = 0; m_vid = 0; m_we = 0; m_pend = 0; m_ovr = 0;
    m_adr = 0; m_wdata = 0; m_viddata = 0; m_rdata = 0; m_be = 0; m_cnt = 0; vstart = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    auto_mem = 0; auto_cpu = 0; auto_vid = 0;
    do_reset();

    // Single video fetch with the documented cycle timing.
    vid_req = 1; step(); vid_req = 0;
    step();
    chk("t1_req_c2", mem_req, 1'b1);
    chk("t1_adr", mem_adr, VID_BASE);
    steps(2);
    chk("t1_req_c4", mem_req, 1'b1);
    ack_now(32'hDEADBEEF);
    chk("t1_viddata", viddata, 32'hDEADBEEF);
    chk("t1_req_c5", mem_req, 1'b0);
    vid_req = 1; step(); vid_req = 0; step();
    chk("t1_next_adr", mem_adr, VID_BASE + 22'd1);
    ack_now(32'h0);

    // CPU read to seed cpu_rdata, then a write that must leave it alone.
    cpu_rd = 1; cpu_adr = 22'h55; step();
    ack_now(32'hCAFEF00D);
    chk("t2_rd_ack", cpu_ack, 1'b1);
    cpu_rd = 0; step();
    cpu_wr = 1; cpu_adr = 22'h100; cpu_wdata = 32'h12345678; cpu_be = 4'h3; step();
    chk("t2_wr", {mem_we, mem_adr, mem_be}, {1'b1, 22'h100, 4'h3});
    chk("t2_wdata", mem_wdata, 32'h12345678);
    steps(2);
    ack_now(32'hFFFFFFFF);
    chk("t2_ack", cpu_ack, 1'b1);
    cpu_wr = 0; step();
    chk("t2_ack_pulse", cpu_ack, 1'b0);
    chk("t2_rdata_kept", cpu_rdata, 32'hCAFEF00D);

    // Video waits behind an in-flight CPU read; coincident requests favour video.
    do_reset();
    cpu_rd = 1; cpu_adr = 22'h2A; step();
    vid_req = 1; step(); vid_req = 0; step();
    ack_now(32'h0BADCAFE);
    chk("t3_cpu_first", cpu_ack, 1'b1);
    chk("t3_gap", mem_req, 1'b0);
    cpu_rd = 0; step();
    chk("t3_vid_after", {mem_req, mem_we, mem_adr}, {1'b1, 1'b0, VID_BASE});
    ack_now(32'h1);
    step();
    cpu_rd = 1; cpu_adr = 22'h77; vid_req = 1; step(); vid_req = 0;
    chk("t3_together_wait", mem_req, 1'b0);
    step();
    chk("t3_together_vid", {mem_req, mem_we, mem_adr}, {1'b1, 1'b0, VID_BASE + 22'd1});
    ack_now(32'h2);
    step();
    chk("t3_cpu_next", {mem_req, mem_we, mem_adr}, {1'b1, 1'b0, 22'h77});
    ack_now(32'h3);
    cpu_rd = 0; step();

    // Saturation of the frame counter, then rewind.
    do_reset();
    mem_ack = 1; mem_rdata = 32'h5A5A5A5A; vid_req = 1; n = 0;
    for (int i = 0; i < 25000; i++) begin
      step();
      if (vstart) begin
        n++;
        if (n >= VID_WORDS) chk("t4_sat_adr", mem_adr, VID_BASE + 22'd9599);
        if (n == VID_WORDS + 5) break;
      end
    end
    chk("t4_fetch_count", n, VID_WORDS + 5);
    vid_req = 0; steps(3); mem_ack = 0;
    vid_frame = 1; step(); vid_frame = 0;
    vid_req = 1; step(); vid_req = 0; step();
    chk("t4_rewind", {mem_req, mem_adr}, {1'b1, VID_BASE});
    ack_now(32'h0);

    // Overrun flag: set by a repeat strobe while pending, not by one on the ack edge.
    do_reset();
    vid_req = 1; step(); step(); vid_req = 0;
    chk("t5_ovr_set", vid_ovr, 1'b1);
    ack_now(32'h11); steps(3);
    chk("t5_ovr_sticky", vid_ovr, 1'b1);
    do_reset();
    vid_req = 1; step(); vid_req = 0; step();
    vid_req = 1; ack_now(32'h22); vid_req = 0;
    chk("t5_no_ovr", vid_ovr, 1'b0);
    step();
    chk("t5_second_fetch", {mem_req, mem_adr}, {1'b1, VID_BASE + 22'd1});
    ack_now(32'h33);
    chk("t5_no_ovr_end", vid_ovr, 1'b0);

    // Reset during a video transaction, then a stray ack.
    vid_req = 1; step(); vid_req = 0; step();
    chk("t6_in_vid", mem_req, 1'b1);
    do_reset();
    mem_ack = 1; mem_rdata = 32'h99999999; step(); mem_ack = 0;
    chk("t6_stray_req", mem_req, 1'b0);
    chk("t6_stray_vid", viddata, 32'd0);
    step();

    // Random traffic from all three sides.
    do_reset();
    auto_mem = 1; auto_cpu = 1; auto_vid = 1;
    steps(3000);
    auto_vid = 0; auto_cpu = 0; vid_req = 0; vid_frame = 0;
    for (int i = 0; i < 40 && (cpu_rd || cpu_wr || mem_req || m_pend); i++) begin
      if (cpu_ack) begin cpu_rd = 0; cpu_wr = 0; end
      step();
    end
    if (cpu_ack) begin cpu_rd = 0; cpu_wr = 0; end
    auto_mem = 0; mem_ack = 0;
    steps(2);
    chk("rand_drained", {mem_req, cpu_rd, cpu_wr}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
